// File: rtl/sqg_pyramid.sv
// 2x2 sum-reduction pyramid over a ping-pong banked RAM: each pass sums every quad of the
// source bank into the other bank. Define SQG_SAT_EN to clamp quad sums and raise sat_flag.
module sqg_pyramid #(
    parameter int BOX_IDX  = 3,
    parameter int DATA_LEN = 8,
    parameter int LVL_W    = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [LVL_W-1:0]      levels,
    input  logic [DATA_LEN-1:0]   x,
    output logic                  rd_en,
    output logic [2*BOX_IDX:0]    rd_addr,
    output logic                  wr_en,
    output logic [2*BOX_IDX:0]    wr_addr,
    output logic [DATA_LEN-1:0]   wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [LVL_W-1:0]      cur_level,
    output logic                  sat_flag
);

    localparam int IW = 2*BOX_IDX;
    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(BOX_IDX);
`ifdef SQG_SAT_EN
    localparam logic [DATA_LEN+1:0] MAXV = {2'b00, {DATA_LEN{1'b1}}};
`endif

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
    state_t state;

    logic [LVL_W-1:0]    num_lvl, lvl_clamp, lvl_nxt;
    logic [IW-1:0]       idx, idx_nxt, idx_last;
    logic [BOX_IDX-1:0]  rd_orow, rd_ocol, n_orow, n_ocol, n_row, n_col;
    logic                p_vld, p_bank;
    logic [1:0]          p_beat;
    logic [BOX_IDX-1:0]  p_orow, p_ocol;
    logic [DATA_LEN+1:0] acc, sum;
    int                  hb, oi;

    // Next read address: idx = {quad index, beat}, quad index splits into output row/col
    // whose width shrinks by one bit per pass.
    always_comb begin
        lvl_clamp = (levels > MAX_LVL) ? MAX_LVL : levels;
        lvl_nxt   = cur_level + LVL_W'(1);
        idx_nxt   = idx + IW'(1);
        hb        = BOX_IDX - 1 - int'(cur_level);
        oi        = int'(idx_nxt) >> 2;
        n_ocol    = BOX_IDX'(oi & ((1 << hb) - 1));
        n_orow    = BOX_IDX'(oi >> hb);
        n_row     = BOX_IDX'(2*int'(n_orow) + int'(idx_nxt[1]));
        n_col     = BOX_IDX'(2*int'(n_ocol) + int'(idx_nxt[0]));
        idx_last  = IW'((1 << (2*(BOX_IDX - int'(cur_level)))) - 1);
        sum       = ((p_beat == 2'd0) ? '0 : acc) + {2'b00, x};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            wr_en     <= 1'b0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cur_level <= '0;
            sat_flag  <= 1'b0;
            num_lvl   <= '0;
            idx       <= '0;
            rd_orow   <= '0;
            rd_ocol   <= '0;
            p_vld     <= 1'b0;
            p_bank    <= 1'b0;
            p_beat    <= '0;
            p_orow    <= '0;
            p_ocol    <= '0;
            acc       <= '0;
        end else begin
            wr_en  <= 1'b0;
            done   <= 1'b0;
            p_vld  <= rd_en;
            p_beat <= idx[1:0];
            p_orow <= rd_orow;
            p_ocol <= rd_ocol;
            p_bank <= rd_addr[2*BOX_IDX];

            // Data beat: first beat of a quad restarts the sum, fourth beat emits it.
            if (p_vld) begin
                acc <= sum;
                if (p_beat == 2'd3) begin
                    wr_en   <= 1'b1;
                    wr_addr <= {~p_bank, p_orow, p_ocol};
`ifdef SQG_SAT_EN
                    if (sum > MAXV) begin
                        wr_data  <= '1;
                        sat_flag <= 1'b1;
                    end else begin
                        wr_data  <= sum[DATA_LEN-1:0];
                    end
`else
                    wr_data <= sum[DATA_LEN-1:0];
`endif
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        sat_flag  <= 1'b0;
                        cur_level <= '0;
                        num_lvl   <= lvl_clamp;
                        idx       <= '0;
                        rd_addr   <= '0;
                        rd_orow   <= '0;
                        rd_ocol   <= '0;
                        if (lvl_clamp == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                            rd_en <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (idx == idx_last) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        idx     <= idx_nxt;
                        rd_addr <= {cur_level[0], n_row, n_col};
                        rd_orow <= n_orow;
                        rd_ocol <= n_ocol;
                    end
                end
                DRAIN: begin
                    // Only the pass's final write can land while draining.
                    if (wr_en) begin
                        cur_level <= lvl_nxt;
                        idx       <= '0;
                        rd_addr   <= {lvl_nxt[0], {IW{1'b0}}};
                        rd_orow   <= '0;
                        rd_ocol   <= '0;
                        if (lvl_nxt == num_lvl) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                            rd_en <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqg_pyramid.sv
// Scoreboard bench for sqg_pyramid: a behavioural pyramid model predicts every read address
// and write; a negedge monitor pops and compares as the DUT strobes.
module tb_sqg_pyramid;
    localparam int B  = 3;
    localparam int D  = 8;
    localparam int LW = 3;
    localparam int AW = 2*B+1;

    logic CLK = 1'b0, RST = 1'b1, start = 1'b0;
    logic [LW-1:0] levels = '0;
    logic [D-1:0]  x = '0;
    logic          rd_en, wr_en, busy, done, sat_flag;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [D-1:0]  wr_data;
    logic [LW-1:0] cur_level;

    sqg_pyramid #(.BOX_IDX(B), .DATA_LEN(D), .LVL_W(LW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .levels(levels), .x(x),
        .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .cur_level(cur_level),
        .sat_flag(sat_flag));

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
    logic [D-1:0] ram [2**AW];
    int           model [2**AW];
    int           exp_rd[$], exp_wa[$], exp_wd[$], q4[$];
    bit           pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic fail_now(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // RAM: data for a read presented in cycle t is driven during cycle t+1.
    always @(negedge CLK) begin
        if (pend) x = ram[pend_addr];
        else      x = D'($urandom);
        pend      = rd_en;
        pend_addr = rd_addr;
        if (wr_en) ram[wr_addr] = wr_data;
    end

    always @(negedge CLK) begin
        if (!RST) begin
            if (rd_en) begin
                rd_cnt++;
                if (exp_rd.size() == 0) fail_now("rd_extra");
                else check("rd_addr", 64'(rd_addr), 64'(exp_rd.pop_front()));
                if (rd_cnt % 4 == 0) q4.push_back(cyc);
            end
            if (wr_en) begin
                wr_cnt++;
                if (exp_wa.size() == 0) fail_now("wr_extra");
                else begin
                    check("wr_addr", 64'(wr_addr), 64'(exp_wa.pop_front()));
                    check("wr_data", 64'(wr_data), 64'(exp_wd.pop_front()));
                end
                if (q4.size() == 0) fail_now("wr_no_quad");
                else check("wr_latency", 64'(cyc - q4.pop_front()), 64'd2);
            end
            if (done) done_cnt++;
        end
    end

    // Reference pyramid: each pass sums quads of the previous result, ping-ponging banks.
    task automatic predict(input int lv, output bit sat);
        int s, h, src, dst, a, total, res;
        sat = 1'b0;
        for (int k = 0; k < lv; k++) begin
            s = 1 << (B - k);
            h = s / 2;
            src = k % 2;
            dst = 1 - src;
            for (int r = 0; r < h; r++)
                for (int c = 0; c < h; c++) begin
                    total = 0;
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++) begin
                            a = (src << (2*B)) + ((2*r + dr) << B) + (2*c + dc);
                            exp_rd.push_back(a);
                            total += model[a];
                        end
`ifdef SQG_SAT_EN
                    if (total > 255) begin res = 255; sat = 1'b1; end
                    else res = total;
`else
                    res = total % 256;
`endif
                    a = (dst << (2*B)) + (r << B) + c;
                    model[a] = res;
                    exp_wa.push_back(a);
                    exp_wd.push_back(res);
                end
        end
    endtask

    task automatic run_case(string tag, int lv, int fill, bit poke, bit rst_mid);
        int leff, n_rd, n_wr, waited;
        bit sat;
        leff = (lv > B) ? B : lv;
        for (int a = 0; a < 2**AW; a++) begin
            if (a < 2**(2*B))
                case (fill)
                    0: ram[a] = 8'd1;
                    1: ram[a] = D'(a);
                    2: ram[a] = 8'hFF;
                    default: ram[a] = D'($urandom_range(0, 255));
                endcase
            else ram[a] = D'($urandom);
            model[a] = int'(ram[a]);
        end
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); q4.delete();
        predict(leff, sat);
        n_rd = exp_rd.size();
        n_wr = exp_wa.size();
        @(negedge CLK);
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
        levels = LW'(lv);
        start  = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check({tag, "_busy_on"}, 64'(busy), 64'd1);
        if (leff == 0) check({tag, "_done_next"}, 64'(done), 64'd1);
        else           check({tag, "_first_rd"}, 64'(rd_en), 64'd1);
        if (poke) begin
            repeat (5) @(negedge CLK);
            levels = 1;
            start  = 1'b1;
            @(negedge CLK);
            start = 1'b0;
        end
        if (rst_mid) begin
            waited = 0;
            while (cur_level != 1 && waited < 2000) begin @(negedge CLK); waited++; end
            if (waited >= 2000) fail_now({tag, "_reach_pass1"});
            repeat (3) @(negedge CLK);
            RST = 1'b1;
            @(negedge CLK);
            check({tag, "_outs_reset"},
                  64'({busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data, cur_level, sat_flag}),
                  64'd0);
            RST = 1'b0;
            exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); q4.delete();
            rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
            repeat (20) @(negedge CLK);
            check({tag, "_no_rd_after"}, 64'(rd_cnt), 64'd0);
            check({tag, "_no_wr_after"}, 64'(wr_cnt), 64'd0);
            check({tag, "_no_done"}, 64'(done_cnt), 64'd0);
            return;
        end
        waited = 0;
        while (done_cnt == 0 && waited < 3000) begin @(negedge CLK); waited++; end
        if (waited >= 3000) fail_now({tag, "_done_timeout"});
        repeat (2) @(negedge CLK);
        check({tag, "_reads"}, 64'(rd_cnt), 64'(n_rd));
        check({tag, "_writes"}, 64'(wr_cnt), 64'(n_wr));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_left_exp"}, 64'(exp_wa.size() + exp_rd.size()), 64'd0);
        check({tag, "_final"}, 64'(ram[(leff % 2) << (2*B)]), 64'(model[(leff % 2) << (2*B)]));
        check({tag, "_sat"}, 64'(sat_flag), 64'(sat));
        check({tag, "_busy_off"}, 64'(busy), 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_outs",
              64'({busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data, cur_level, sat_flag}),
              64'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        run_case("ones_l3", 3, 0, 0, 0);
        check("ones_reads84", 64'(rd_cnt), 64'd84);
        check("ones_writes21", 64'(wr_cnt), 64'd21);
        check("ones_sum64", 64'(ram[64]), 64'd64);

        run_case("ramp_l1", 1, 1, 0, 0);
        check("ramp_cell00", 64'(ram[64]), 64'd18);
        check("ramp_writes16", 64'(wr_cnt), 64'd16);

        run_case("ff_l1", 1, 2, 0, 0);
`ifdef SQG_SAT_EN
        check("ff_cell00", 64'(ram[64]), 64'd255);
        check("ff_satflag", 64'(sat_flag), 64'd1);
`else
        check("ff_cell00", 64'(ram[64]), 64'd252);
        check("ff_satflag", 64'(sat_flag), 64'd0);
`endif

        run_case("l0", 0, 3, 0, 0);
        check("l0_reads", 64'(rd_cnt), 64'd0);
        check("l0_writes", 64'(wr_cnt), 64'd0);

        run_case("l7", 7, 3, 0, 0);
        check("l7_reads84", 64'(rd_cnt), 64'd84);

        run_case("poke", 3, 3, 1, 0);
        check("poke_writes21", 64'(wr_cnt), 64'd21);

        run_case("rst", 3, 3, 0, 1);
        run_case("after_rst", 3, 0, 0, 0);
        check("after_rst_sum64", 64'(ram[64]), 64'd64);

        for (int i = 0; i < 6; i++) run_case("rand", int'($urandom_range(1, 3)), 3, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sqg_pyramid.md
SQG_PYRAMID -- requirements
Module: sqg_pyramid

Interface
REQ-001 SHALL have parameter BOX_IDX, default 3: log2 of grid side; the grid is 2^BOX_IDX x 2^BOX_IDX.
REQ-002 SHALL have parameter DATA_LEN, default 8: cell data width.
REQ-003 SHALL have parameter LVL_W, default 3: width of `levels`.
REQ-004 SHALL have one clock and a synchronous, active-high reset: CLK input 1, rising-edge clock.
REQ-005 SHALL have RST input 1: synchronous active-high reset.
REQ-006 SHALL have start input 1: begin a reduction run; sampled only in IDLE.
REQ-007 SHALL have levels input LVL_W: number of 2x2 reduction passes; sampled with start.
REQ-008 SHALL have x input DATA_LEN: RAM read data, valid 1 cycle after rd_en.
REQ-009 SHALL have rd_en output 1: RAM read strobe.
REQ-010 SHALL have rd_addr output 2*BOX_IDX+1: {bank, row[BOX_IDX-1:0], col[BOX_IDX-1:0]}.
REQ-011 SHALL have wr_en output 1: RAM write strobe.
REQ-012 SHALL have wr_addr output 2*BOX_IDX+1: same format as rd_addr.
REQ-013 SHALL have wr_data output DATA_LEN: sum of one 2x2 quad.
REQ-014 SHALL have busy output 1: high from the cycle after start acceptance through the done cycle.
REQ-015 SHALL have done output 1: one-cycle pulse at end of run.
REQ-016 SHALL have cur_level output LVL_W: index of the pass in progress, 0-based.
REQ-017 SHALL have sat_flag output 1: sticky overflow indicator, cleared at start acceptance.

Function
REQ-018 SHALL implement FSM IDLE -> READ -> DRAIN -> (READ | DONE) -> IDLE; DONE lasts exactly 1 cycle with done=1.
REQ-019 SHALL compute, in pass k (k=0..L-1), side S=2^(BOX_IDX-k), source bank k[0] and destination bank ~k[0].
REQ-020 SHALL issue in READ one read per cycle, S*S reads, ordered per output (r,c) row-major as (2r,2c),(2r,2c+1),(2r+1,2c),(2r+1,2c+1).
REQ-021 SHALL assert wr_en, wr_addr={~k[0], r, c} and wr_data=sum of the quad exactly 2 cycles after the rd_en cycle of the quad's 4th read.
REQ-022 SHALL stay in DRAIN until the final write of the pass is issued, then increment cur_level; the next pass's first rd_en follows in the next cycle, so the first read of pass k+1 is issued after every write of pass k.
REQ-023 SHALL give rd_en its first assertion in the cycle after start is sampled in IDLE; start while busy SHALL be ignored.
REQ-024 SHALL clamp levels to BOX_IDX when levels>BOX_IDX; levels=0 SHALL go IDLE->DONE directly, with no reads and no writes.
REQ-025 SHALL leave the final result at address {L[0], 0, 0}.
REQ-026 SHALL reset its accumulator at each quad's first data beat; there SHALL be no carry between quads or passes.
REQ-027 SHALL restore all reset values in the next cycle when RST is asserted mid-run; no further rd_en or wr_en SHALL be issued and no done SHALL pulse.

Reset
REQ-028 SHALL, on RST, go to state IDLE with busy=0, done=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, cur_level=0 and sat_flag=0.

Configuration
REQ-029 SHALL use macro SQG_SAT_EN: when defined, each quad sum clamps to 2^DATA_LEN-1 and sat_flag is set on any clamp.
REQ-030 SHALL, when SQG_SAT_EN is undefined, wrap each sum modulo 2^DATA_LEN and tie sat_flag to 0.

Verification
REQ-031 SHALL cover: BOX_IDX=3, all cells in bank 0 = 1, levels=3 -> 84 reads, 21 writes, bank 1 addr 0 = 64, one done pulse, sat_flag=0.
REQ-032 SHALL cover: levels=1, bank 0 cell(r,c)=r*8+c -> 16 writes to bank 1; cell(0,0)=0+1+8+9=18; each wr_en exactly 2 cycles after the 4th rd_en of its quad.
REQ-033 SHALL cover: all cells 0xFF, levels=1 -> with SQG_SAT_EN wr_data=0xFF and sat_flag=1; without it wr_data=0xFC and sat_flag=0.
REQ-034 SHALL cover: levels=0 -> done in the cycle after start, zero rd_en and zero wr_en; levels=7 -> behaves as levels=3.
REQ-035 SHALL cover: RST asserted during pass 1 -> next cycle all outputs at reset values; a following start completes a normal run.
REQ-036 SHALL cover: start pulsed while busy -> ignored, and the run's read/write counts are unchanged.
